// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU: commits register writes, drives the data
// memory port and branch redirects, and stalls upstream for MUL and LWI.
module alu_writeback #(
  parameter int SIZE    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      Control,
  input  logic [SIZE-1:0] alu_out,
  input  logic            zero,
  input  logic [4:0]      rd,
  input  logic [SIZE-1:0] store_data,
  input  logic [SIZE-1:0] branch_target,
  input  logic [SIZE-1:0] mem_rdata,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [SIZE-1:0] wb_data,
  output logic            mem_re,
  output logic            mem_we,
  output logic [SIZE-1:0] mem_addr,
  output logic [SIZE-1:0] mem_wdata,
  output logic            branch_taken,
  output logic [SIZE-1:0] branch_pc,
  output logic            illegal_op,
  output logic [1:0]      dbg_state
);

  // Handshake: an op is taken on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and upstream keeps the multiplier
  // operands and Control stable while in_ready is low.

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MUL_WAIT  = 2'd1,
    S_LOAD_WAIT = 2'd2
  } state_t;

  localparam logic [5:0] OP_NOOP = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h20;
  localparam logic [5:0] OP_MUL  = 6'h16;
  localparam logic [5:0] OP_LWI  = 6'h3B;
  localparam logic [5:0] OP_SWI  = 6'h3C;

  // The product is captured on the MUL_LAT-th wait edge and written one edge later.
  localparam logic [3:0] CNT_SAMPLE = 4'(MUL_LAT - 1);
  localparam logic [3:0] CNT_LAST   = 4'(MUL_LAT);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic [SIZE-1:0] mul_q, mul_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [SIZE-1:0] wb_data_q, wb_data_d;
  logic            mem_re_q, mem_re_d;
  logic            mem_we_q, mem_we_d;
  logic [SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic            br_q, br_d;
  logic [SIZE-1:0] br_pc_q, br_pc_d;
  logic            ill_q, ill_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    mul_d       = mul_q;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    br_d        = 1'b0;
    br_pc_d     = br_pc_q;
    ill_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (Control)
            6'h10, 6'h12, 6'h13, 6'h14, 6'h15,
            6'h32, 6'h33, 6'h34, 6'h35, 6'h39: begin
              wb_en_d   = 1'b1;
              wb_addr_d = rd;
              wb_data_d = alu_out;
            end
            OP_NOOP: ;
            OP_BEQ: begin
              br_d    = zero;
              br_pc_d = branch_target;
            end
            OP_MUL: begin
              rd_d    = rd;
              cnt_d   = 4'd0;
              state_d = S_MUL_WAIT;
            end
            OP_LWI: begin
              rd_d       = rd;
              mem_re_d   = 1'b1;
              mem_addr_d = alu_out;
              state_d    = S_LOAD_WAIT;
            end
            OP_SWI: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = alu_out;
              mem_wdata_d = store_data;
            end
            default: ill_d = 1'b1;
          endcase
        end
      end
      S_MUL_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          wb_en_d   = 1'b1;
          wb_addr_d = rd_q;
          wb_data_d = mul_q;
          cnt_d     = 4'd0;
          state_d   = S_IDLE;
        end else begin
          if (cnt_q == CNT_SAMPLE) mul_d = alu_out;
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_LOAD_WAIT: begin
        wb_en_d   = 1'b1;
        wb_addr_d = rd_q;
        wb_data_d = mem_rdata;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rd_q        <= 5'd0;
      mul_q       <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      br_q        <= 1'b0;
      br_pc_q     <= '0;
      ill_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      mul_q       <= mul_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      br_q        <= br_d;
      br_pc_q     <= br_pc_d;
      ill_q       <= ill_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign wb_en        = wb_en_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign mem_re       = mem_re_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign branch_taken = br_q;
  assign branch_pc    = br_pc_q;
  assign illegal_op   = ill_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: an event-scheduling model predicts every
// output each cycle, and literal checks pin the key transactions.
module tb_alu_writeback;

  localparam int SIZE    = 32;
  localparam int MUL_LAT = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [5:0]      Control = 6'h00;
  logic [SIZE-1:0] alu_out = '0;
  logic            zero = 1'b0;
  logic [4:0]      rd = 5'd0;
  logic [SIZE-1:0] store_data = '0;
  logic [SIZE-1:0] branch_target = '0;
  logic [SIZE-1:0] mem_rdata = 32'h0000_1111;
  logic            wb_en, mem_re, mem_we, branch_taken, illegal_op;
  logic [4:0]      wb_addr;
  logic [SIZE-1:0] wb_data, mem_addr, mem_wdata, branch_pc;
  logic [1:0]      dbg_state;

  alu_writeback #(.SIZE(SIZE), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Control(Control), .alu_out(alu_out), .zero(zero), .rd(rd),
    .store_data(store_data), .branch_target(branch_target), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .illegal_op(illegal_op),
    .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Every accepted op becomes a list of timed events (by edge number);
  // the model replays them and tracks when the stage is free again.
  localparam int K_WB = 0, K_BR = 1, K_RD = 2, K_WR = 3, K_ILL = 4,
                 K_MSAMPLE = 5, K_MWB = 6, K_LWB = 7;
  typedef struct {
    int          at;
    int          kind;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] data2;
  } act_t;
  act_t pend[$];

  int          edge_n = 0;
  int          ready_at = 0;
  logic        m_wb_en = 0, m_mem_re = 0, m_mem_we = 0, m_br = 0, m_ill = 0;
  logic [4:0]  m_wb_addr = 0;
  logic [31:0] m_wb_data = 0, m_mem_addr = 0, m_mem_wdata = 0, m_br_pc = 0, m_mul_hold = 0;

  function automatic bit is_alu_op(input logic [5:0] op);
    logic [5:0] alu_ops [10] = '{6'h10, 6'h12, 6'h13, 6'h14, 6'h15,
                                 6'h32, 6'h33, 6'h34, 6'h35, 6'h39};
    foreach (alu_ops[i]) if (alu_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
      ready_at = 0;
      {m_wb_en, m_mem_re, m_mem_we, m_br, m_ill} = '0;
      m_wb_addr = 0; m_wb_data = 0; m_mem_addr = 0; m_mem_wdata = 0; m_br_pc = 0;
    end else begin
      edge_n++;
      {m_wb_en, m_mem_re, m_mem_we, m_br, m_ill} = '0;
      if (in_valid && edge_n >= ready_at) begin
        ready_at = edge_n + 1;
        if (is_alu_op(Control)) pend.push_back('{edge_n, K_WB, rd, alu_out, 0});
        else if (Control == 6'h00) ;
        else if (Control == 6'h20) pend.push_back('{edge_n, K_BR, {4'd0, zero}, branch_target, 0});
        else if (Control == 6'h16) begin
          pend.push_back('{edge_n + MUL_LAT, K_MSAMPLE, 0, 0, 0});
          pend.push_back('{edge_n + MUL_LAT + 1, K_MWB, rd, 0, 0});
          ready_at = edge_n + MUL_LAT + 2;
        end else if (Control == 6'h3B) begin
          pend.push_back('{edge_n, K_RD, 0, alu_out, 0});
          pend.push_back('{edge_n + 1, K_LWB, rd, 0, 0});
          ready_at = edge_n + 2;
        end else if (Control == 6'h3C) pend.push_back('{edge_n, K_WR, 0, alu_out, store_data});
        else pend.push_back('{edge_n, K_ILL, 0, 0, 0});
      end
      for (int i = 0; i < pend.size(); ) begin
        if (pend[i].at == edge_n) begin
          case (pend[i].kind)
            K_WB:      begin m_wb_en = 1; m_wb_addr = pend[i].addr; m_wb_data = pend[i].data; end
            K_BR:      begin m_br = pend[i].addr[0]; m_br_pc = pend[i].data; end
            K_RD:      begin m_mem_re = 1; m_mem_addr = pend[i].data; end
            K_WR:      begin m_mem_we = 1; m_mem_addr = pend[i].data; m_mem_wdata = pend[i].data2; end
            K_ILL:     m_ill = 1;
            K_MSAMPLE: m_mul_hold = alu_out;
            K_MWB:     begin m_wb_en = 1; m_wb_addr = pend[i].addr; m_wb_data = m_mul_hold; end
            K_LWB:     begin m_wb_en = 1; m_wb_addr = pend[i].addr; m_wb_data = mem_rdata; end
            default: ;
          endcase
          pend.delete(i);
        end else i++;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    chk("in_ready",     32'(in_ready),     32'(edge_n + 1 >= ready_at));
    chk("wb_en",        32'(wb_en),        32'(m_wb_en));
    chk("wb_addr",      32'(wb_addr),      32'(m_wb_addr));
    chk("wb_data",      wb_data,           m_wb_data);
    chk("mem_re",       32'(mem_re),       32'(m_mem_re));
    chk("mem_we",       32'(mem_we),       32'(m_mem_we));
    chk("mem_addr",     mem_addr,          m_mem_addr);
    chk("mem_wdata",    mem_wdata,         m_mem_wdata);
    chk("branch_taken", 32'(branch_taken), 32'(m_br));
    chk("branch_pc",    branch_pc,         m_br_pc);
    chk("illegal_op",   32'(illegal_op),   32'(m_ill));
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic [5:0] op, input logic [31:0] a, input logic [4:0] r);
    @(negedge clk);
    Control  = op;
    alu_out  = a;
    rd       = r;
    in_valid = 1'b1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [5:0] alu_tab [10] = '{6'h10, 6'h12, 6'h13, 6'h14, 6'h15,
                                 6'h32, 6'h33, 6'h34, 6'h35, 6'h39};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    reset = 1'b0;

    // ADD to r3
    put(6'h10, 32'h0000_0007, 5'd3);
    idle(1);
    chk("add_wb_en", 32'(wb_en), 32'd1);
    chk("add_wb_addr", 32'(wb_addr), 32'd3);
    chk("add_wb_data", wb_data, 32'd7);
    chk("add_in_ready", 32'(in_ready), 32'd1);
    idle(1);
    chk("add_pulse_end", 32'(wb_en), 32'd0);
    chk("add_hold_data", wb_data, 32'd7);

    // MUL: product not yet valid at accept; upstream retries while busy
    put(6'h16, 32'h0000_0BAD, 5'd5);
    @(negedge clk);
    alu_out = 32'h0000_0C00;
    rd      = 5'd7;
    chk("mul_busy1", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("mul_busy2", 32'(in_ready), 32'd0);
    chk("mul_no_early_wb", 32'(wb_en), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mul_busy3", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("mul_ready", 32'(in_ready), 32'd1);
    chk("mul_wb_en", 32'(wb_en), 32'd1);
    chk("mul_wb_addr", 32'(wb_addr), 32'd5);
    chk("mul_wb_data", wb_data, 32'h0000_0C00);
    idle(1);
    chk("mul_single_wb", 32'(wb_en), 32'd0);

    // BEQ taken then not taken
    zero = 1'b1; branch_target = 32'h40;
    put(6'h20, 32'h999, 5'd1);
    idle(1);
    chk("beq_taken", 32'(branch_taken), 32'd1);
    chk("beq_pc", branch_pc, 32'h40);
    chk("beq_no_wb", 32'(wb_en), 32'd0);
    zero = 1'b0; branch_target = 32'h80;
    put(6'h20, 32'h999, 5'd1);
    idle(1);
    chk("beq_not_taken", 32'(branch_taken), 32'd0);

    // LWI to r9
    put(6'h3B, 32'h100, 5'd9);
    @(negedge clk);
    in_valid  = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    chk("lwi_mem_re", 32'(mem_re), 32'd1);
    chk("lwi_mem_addr", mem_addr, 32'h100);
    chk("lwi_busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    mem_rdata = 32'h0000_2222;
    chk("lwi_wb_en", 32'(wb_en), 32'd1);
    chk("lwi_wb_data", wb_data, 32'hDEAD_BEEF);
    chk("lwi_wb_addr", 32'(wb_addr), 32'd9);
    chk("lwi_re_end", 32'(mem_re), 32'd0);

    // SWI then an unknown opcode
    store_data = 32'h55;
    put(6'h3C, 32'h20, 5'd4);
    idle(1);
    chk("swi_mem_we", 32'(mem_we), 32'd1);
    chk("swi_mem_addr", mem_addr, 32'h20);
    chk("swi_mem_wdata", mem_wdata, 32'h55);
    chk("swi_no_wb", 32'(wb_en), 32'd0);
    put(6'h3F, 32'h77, 5'd6);
    idle(1);
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    chk("ill_no_wb", 32'(wb_en), 32'd0);
    chk("ill_no_we", 32'(mem_we), 32'd0);
    chk("ill_addr_hold", mem_addr, 32'h20);

    // back-to-back single-cycle ops, NOOP, rd=0, and a MUL right after
    foreach (alu_tab[i]) put(alu_tab[i], 32'(alu_tab[i]) * 32'h1010, 5'(i * 3));
    put(6'h00, 32'hFFFF, 5'd2);
    put(6'h33, 32'hA2, 5'd0);
    put(6'h16, 32'h0000_3030, 5'd11);
    idle(1);
    chk("b2b_rd0_wb", 32'(wb_addr), 32'd0);
    idle(MUL_LAT + 2);

    // reset abandons a MUL in flight
    put(6'h16, 32'h1234, 5'd8);
    idle(1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_wb_data", wb_data, 32'd0);
    chk("rst_async_mem_wdata", mem_wdata, 32'd0);
    chk("rst_async_branch_pc", branch_pc, 32'd0);
    chk("rst_async_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    idle(5);
    put(6'h10, 32'h2A, 5'd2);
    idle(1);
    chk("post_rst_add_en", 32'(wb_en), 32'd1);
    chk("post_rst_add_data", wb_data, 32'h2A);

    // reset abandons an LWI in flight
    put(6'h3B, 32'h300, 5'd12);
    idle(1);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(4);
    chk("rst_lwi_no_wb", 32'(wb_en), 32'd0);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
